tx_byte_scheduler: RTL and testbench
====================================

# tx_byte_scheduler

Shares one 8-bit I3C target transmit path between two word-wide sources: requester 0 is the TTI TX queue and requester 1 is the IBI queue. The block takes a length descriptor from a requester, pulls ceil(len/Bytes) data words from that requester and serialises them LSB-byte-first. It drops the padding bytes of the final word and marks the last byte for the target FSM. It sits between the TTI/IBI queues and the I3C target FSM. It replaces a bare Nto8 width converter, which cannot handle byte-granular lengths or arbitration.

## Interface
Parameters:
- Width, 32: data word width; multiple of 8, at least 16; Bytes = Width/8
- LenWidth, 16: descriptor byte-length width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- desc_valid_i  in  2  per-requester descriptor valid
- desc_ready_o  out  2  per-requester descriptor accept
- desc_len_i  in  2×LenWidth  per-requester byte length
- data_valid_i  in  2  per-requester data word valid
- data_ready_o  out  2  per-requester data word accept
- data_i  in  2×Width  per-requester data words
- abort_i  in  1  abandon current transfer (target FSM saw bus error or STOP)
- byte_valid_o  out  1  output byte valid
- byte_ready_i  in  1  target FSM accepts byte
- byte_o  out  8  output byte
- byte_last_o  out  1  final byte of the transfer
- byte_src_o  out  1  requester id of the current transfer
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN. Reset state is IDLE.
- IDLE:
  - Round-robin grant between requesters with desc_valid_i set. The winner is the requester ≠ last_served. last_served resets to 1, so requester 0 wins the first tie.
  - desc_ready_o is one-hot on the winner, is combinational from desc_valid_i, and is zero when desc_valid_i is zero.
  - On handshake: latch src and len, update last_served, compute words = ceil(len/Bytes).
  - len ≠ 0 → LOAD. len = 0 → stay in IDLE; the descriptor is consumed and no byte is emitted.
- LOAD:
  - data_ready_o[src] = 1.
  - On handshake: capture the word into the shift register and decrement words.
  - Set bytes_in_word = Bytes, except on the final word, where it is len mod Bytes (Bytes if that result is 0).
  - Go to SHIFT.
- SHIFT:
  - byte_o = sreg[7:0] and byte_valid_o = 1.
  - On each byte handshake: shift sreg right by 8 and decrement bytes_in_word and the remaining-byte counter.
  - byte_last_o = 1 exactly when the remaining-byte counter = 1.
  - After the last byte of a word: go to LOAD if words > 0, otherwise IDLE.
- abort_i:
  - Sampled in LOAD or SHIFT. Clears sreg and byte_valid_o the next cycle.
  - If words > 0 → DRAIN; otherwise → IDLE.
  - abort_i in IDLE or DRAIN is ignored.
- DRAIN: data_ready_o[src] = 1. Consume and discard the remaining words of this descriptor, then go to IDLE. This keeps the queue aligned to descriptor boundaries.
- Reset values: desc_ready_o = 0, data_ready_o = 0, byte_valid_o = 0, byte_o = 0, byte_last_o = 0, byte_src_o = 0, busy_o = 0, last_served = 1.
- The data of the non-granted requester is never accepted.

## Timing
- Descriptor handshake at cycle N → data_ready_o high at N+1.
- Word handshake at cycle M → first byte valid at M+1.
- One bubble cycle at each word boundary (SHIFT→LOAD). A full Width=32 word therefore takes ≥5 cycles.
- byte_o, byte_last_o and byte_src_o stay stable while byte_valid_o=1 and byte_ready_i=0.
- An abort in the same cycle as a byte handshake: the byte counts as transferred and the abort still takes effect.
- rst_i mid-transfer returns to IDLE in the next cycle with all reset values. Partially consumed queue words are not restored.
- Minimum gap between transfers: one IDLE cycle.

## Structure
- i3c_ctrl_pkg holds:
  - the tx_src_e enum {TxSrcTti=0, TxSrcIbi=1}
  - the FSM state enum
  - TxLenWidth
- Sub-module tx_word_serializer: a Width-to-8 shift register with a bytes-valid count, load/shift/clear controls and an empty flag.
- The top level holds the arbiter, the FSM and the word and byte counters.

## Test plan
- Width=32, requester 0, len=6, words 0x44332211 and 0x88776655 → bytes 11 22 33 44 55 66. byte_last_o is set only on 0x66 and byte_src_o=0. Bytes 77 and 88 are never output.
- Both desc_valid_i set from reset, each len=1 → order is req0, req1, req0, req1 with no starvation.
- len=0 on requester 1 → desc_ready_o[1] pulses once, no byte_valid_o, busy_o stays 0.
- byte_ready_i held 0 for 10 cycles mid-word → outputs held stable. Resume gives the correct sequence and per-word bubbles only.
- len=12, abort_i after the 2nd byte → byte_valid_o=0 next cycle. The remaining 2 words are drained via data_ready_o. The next descriptor starts on a fresh word.
- rst_i asserted in SHIFT → all outputs at reset values next cycle. A new descriptor is accepted after rst_i falls.

Source files
------------

// File: rtl/i3c_ctrl_pkg.sv
// Shared types for the I3C target controller transmit path.
package i3c_ctrl_pkg;

    localparam int unsigned TxLenWidth = 16;

    typedef enum logic {
        TxSrcTti = 1'b0,
        TxSrcIbi = 1'b1
    } tx_src_e;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxLoad  = 2'd1,
        TxShift = 2'd2,
        TxDrain = 2'd3
    } tx_sched_state_e;

endpackage

// File: rtl/tx_word_serializer.sv
// Width-to-8 shift register: emits the LSB byte first and tracks how many
// bytes of the loaded word are still valid.
module tx_word_serializer #(
    parameter int unsigned Width = 32,
    localparam int unsigned Bytes = Width / 8,
    localparam int unsigned CntWidth = $clog2(Bytes + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic                clear_i,
    input  logic [Width-1:0]    word_i,
    input  logic [CntWidth-1:0] nbytes_i,
    output logic [7:0]          byte_o,
    output logic [CntWidth-1:0] count_o,
    output logic                empty_o
);

    logic [Width-1:0]    sreg_q, sreg_d;
    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        sreg_d  = sreg_q;
        count_d = count_q;
        if (clear_i) begin
            sreg_d  = '0;
            count_d = '0;
        end else if (load_i) begin
            sreg_d  = word_i;
            count_d = nbytes_i;
        end else if (shift_i && (count_q != '0)) begin
            // Wipe the register on the final byte so padding never reaches byte_o.
            if (count_q == CntWidth'(1)) begin
                sreg_d = '0;
            end else begin
                sreg_d = {8'h00, sreg_q[Width-1:8]};
            end
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q  <= '0;
            count_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            count_q <= count_d;
        end
    end

    assign byte_o  = sreg_q[7:0];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/tx_byte_scheduler.sv
// Arbitrates TTI/IBI transmit descriptors and streams their words to the
// target FSM one byte at a time, trimming the final word to the byte length.
module tx_byte_scheduler
    import i3c_ctrl_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned LenWidth = TxLenWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               desc_valid_i,
    output logic [1:0]               desc_ready_o,
    input  logic [1:0][LenWidth-1:0] desc_len_i,
    input  logic [1:0]               data_valid_i,
    output logic [1:0]               data_ready_o,
    input  logic [1:0][Width-1:0]    data_i,
    input  logic                     abort_i,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic [7:0]               byte_o,
    output logic                     byte_last_o,
    output logic                     byte_src_o,
    output logic                     busy_o
);

    localparam int unsigned Bytes    = Width / 8;
    localparam int unsigned CntWidth = $clog2(Bytes + 1);
    localparam int unsigned LenExtW  = LenWidth + 1;

    tx_sched_state_e     state_q, state_d;
    tx_src_e             src_q, src_d;
    tx_src_e             last_served_q, last_served_d;
    logic [LenWidth-1:0] words_q, words_d;
    logic [LenWidth-1:0] rem_q, rem_d;
    logic [LenWidth-1:0] words_left;

    logic [1:0]          grant;
    tx_src_e             grant_src;
    logic [LenWidth-1:0] grant_len;
    logic [LenExtW-1:0]  grant_len_rnd;
    logic [LenWidth-1:0] grant_words;
    logic [Width-1:0]    src_word;
    logic                data_hs;
    logic                byte_hs;
    logic                ser_load, ser_shift, ser_clear, ser_empty;
    logic [CntWidth-1:0] ser_count, ser_nbytes;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grant = desc_valid_i;
        if (desc_valid_i == 2'b11) begin
            grant = (last_served_q == TxSrcTti) ? 2'b10 : 2'b01;
        end
    end

    assign grant_src     = grant[1] ? TxSrcIbi : TxSrcTti;
    assign grant_len     = grant[1] ? desc_len_i[1] : desc_len_i[0];
    assign grant_len_rnd = {1'b0, grant_len} + LenExtW'(Bytes - 1);
    assign grant_words   = LenWidth'(grant_len_rnd / LenExtW'(Bytes));
    assign desc_ready_o  = (state_q == TxIdle) ? grant : 2'b00;

    assign data_ready_o = ((state_q == TxLoad) || (state_q == TxDrain))
                        ? {src_q == TxSrcIbi, src_q == TxSrcTti} : 2'b00;
    assign data_hs      = |(data_valid_i & data_ready_o);
    assign src_word     = (src_q == TxSrcIbi) ? data_i[1] : data_i[0];

    // Final word carries only the bytes still owed to the descriptor.
    assign ser_nbytes = (rem_q < LenWidth'(Bytes)) ? CntWidth'(rem_q) : CntWidth'(Bytes);

    assign byte_valid_o = (state_q == TxShift) && !ser_empty;
    assign byte_hs      = byte_valid_o && byte_ready_i;
    assign byte_last_o  = (state_q == TxShift) && (rem_q == LenWidth'(1));
    assign byte_src_o   = (src_q == TxSrcIbi);
    assign busy_o       = (state_q != TxIdle);

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        last_served_d = last_served_q;
        words_d       = words_q;
        rem_d         = rem_q;
        words_left    = words_q;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        ser_clear     = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (grant != 2'b00) begin
                    src_d         = grant_src;
                    last_served_d = grant_src;
                    rem_d         = grant_len;
                    words_d       = grant_words;
                    if (grant_len != '0) begin
                        state_d = TxLoad;
                    end
                end
            end
            TxLoad: begin
                if (abort_i) begin
                    // A word accepted alongside the abort still counts as consumed.
                    words_left = words_q - LenWidth'(data_hs);
                    words_d    = words_left;
                    rem_d      = '0;
                    ser_clear  = 1'b1;
                    state_d    = (words_left != '0) ? TxDrain : TxIdle;
                end else if (data_hs) begin
                    ser_load = 1'b1;
                    words_d  = words_q - LenWidth'(1);
                    state_d  = TxShift;
                end
            end
            TxShift: begin
                if (abort_i) begin
                    rem_d     = '0;
                    ser_clear = 1'b1;
                    state_d   = (words_q != '0) ? TxDrain : TxIdle;
                end else if (byte_hs) begin
                    ser_shift = 1'b1;
                    rem_d     = rem_q - LenWidth'(1);
                    if (ser_count == CntWidth'(1)) begin
                        state_d = (words_q != '0) ? TxLoad : TxIdle;
                    end
                end
            end
            TxDrain: begin
                if (data_hs) begin
                    words_d = words_q - LenWidth'(1);
                    if (words_q == LenWidth'(1)) begin
                        state_d = TxIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= TxIdle;
            src_q         <= TxSrcTti;
            last_served_q <= TxSrcIbi;
            words_q       <= '0;
            rem_q         <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            last_served_q <= last_served_d;
            words_q       <= words_d;
            rem_q         <= rem_d;
        end
    end

    tx_word_serializer #(
        .Width (Width)
    ) u_serializer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ser_load),
        .shift_i  (ser_shift),
        .clear_i  (ser_clear),
        .word_i   (src_word),
        .nbytes_i (ser_nbytes),
        .byte_o   (byte_o),
        .count_o  (ser_count),
        .empty_o  (ser_empty)
    );

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// Directed bench for tx_byte_scheduler with queue-backed requesters and a
// byte scoreboard.
module tb_tx_byte_scheduler;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [1:0]        desc_valid_i;
    logic [1:0]        desc_ready_o;
    logic [1:0][15:0]  desc_len_i;
    logic [1:0]        data_valid_i;
    logic [1:0]        data_ready_o;
    logic [1:0][31:0]  data_i;
    logic              abort_i;
    logic              byte_valid_o;
    logic              byte_ready_i;
    logic [7:0]        byte_o;
    logic              byte_last_o;
    logic              byte_src_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wq0[$];
    logic [31:0] wq1[$];
    logic [10:0] expq[$];   // {present, src, last, byte}
    logic [10:0] expd;

    tx_byte_scheduler #(.Width(32), .LenWidth(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_len_i   (desc_len_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_i       (data_i),
        .abort_i      (abort_i),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_o       (byte_o),
        .byte_last_o  (byte_last_o),
        .byte_src_o   (byte_src_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Requester queues and byte scoreboard; sampled 1 time unit before posedge.
    always @(negedge clk) begin
        data_valid_i[0] = (wq0.size() != 0);
        data_i[0]       = (wq0.size() != 0) ? wq0[0] : 32'h0;
        data_valid_i[1] = (wq1.size() != 0);
        data_i[1]       = (wq1.size() != 0) ? wq1[0] : 32'h0;
        #4;
        if (!rst_i) begin
            if (data_valid_i[0] && data_ready_o[0]) void'(wq0.pop_front());
            if (data_valid_i[1] && data_ready_o[1]) void'(wq1.pop_front());
            if (byte_valid_o && byte_ready_i) begin
                expd = 11'h0;
                if (expq.size() != 0) expd = expq.pop_front();
                check("byte_stream", 64'({1'b1, byte_src_o, byte_last_o, byte_o}), 64'(expd));
            end
        end
    end

    function automatic void load_words(input int r, input logic [95:0] w, input int nw);
        for (int i = 0; i < nw; i++) begin
            if (r == 0) wq0.push_back(w[32*i +: 32]);
            else        wq1.push_back(w[32*i +: 32]);
        end
    endfunction

    function automatic void expect_bytes(input int r, input int len, input logic [95:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            expq.push_back({1'b1, 1'(r), (i == len - 1), w[8*i +: 8]});
        end
    endfunction

    // Entered and left right after a negedge.
    task automatic send_desc(input int r, input int len);
        bit done;
        done = 1'b0;
        desc_len_i[r]   = 16'(len);
        desc_valid_i[r] = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            #4;
            if (desc_ready_o[r]) begin
                done = 1'b1;
                check("desc_onehot", 64'(desc_ready_o), 64'((r == 1) ? 2'b10 : 2'b01));
            end
            @(negedge clk);
        end
        desc_valid_i[r] = 1'b0;
        check("desc_handshake", 64'(done), 64'(1));
    endtask

    task automatic wait_bytes(input int n, output int first_c, output int last_c);
        int got;
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 200 && got < n; c++) begin
            #4;
            if (byte_valid_o && byte_ready_i) begin
                if (got == 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
            @(negedge clk);
        end
        check("byte_count", 64'(got), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (c < 200) begin
            #4;
            if (!busy_o && expq.size() == 0) break;
            @(negedge clk);
            c++;
        end
        check(tag, 64'(c < 200), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        int n, rem0, rem1, f0, l0, f1, l1;
        bit seen, stable_ok;
        logic [10:0] held;
        logic [1:0] exp_grant;

        rst_i = 1'b1; desc_valid_i = '0; desc_len_i = '0; abort_i = 1'b0; byte_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("reset_ctrl", 64'({byte_valid_o, busy_o, byte_last_o, byte_src_o}), 64'(0));
        check("reset_ready", 64'({data_ready_o, desc_ready_o}), 64'(0));
        check("reset_byte", 64'(byte_o), 64'(0));
        @(negedge clk);
        rst_i = 1'b0;
        byte_ready_i = 1'b1;

        // Both requesters contend from reset: expect 0,1,0,1.
        load_words(0, {64'h0, 32'h000000A2, 32'h000000A1}, 2);
        load_words(1, {64'h0, 32'h000000B2, 32'h000000B1}, 2);
        expq.push_back({1'b1, 1'b0, 1'b1, 8'hA1});
        expq.push_back({1'b1, 1'b1, 1'b1, 8'hB1});
        expq.push_back({1'b1, 1'b0, 1'b1, 8'hA2});
        expq.push_back({1'b1, 1'b1, 1'b1, 8'hB2});
        desc_len_i[0] = 16'd1; desc_len_i[1] = 16'd1;
        desc_valid_i = 2'b11;
        n = 0; rem0 = 2; rem1 = 2;
        for (int c = 0; c < 200 && n < 4; c++) begin
            #4;
            if (desc_ready_o != 2'b00) begin
                exp_grant = (n % 2 == 0) ? 2'b01 : 2'b10;
                check("arb_order", 64'(desc_ready_o), 64'(exp_grant));
                if (desc_ready_o[0]) rem0--; else rem1--;
                n++;
            end
            @(negedge clk);
            desc_valid_i = {rem1 != 0, rem0 != 0};
        end
        check("arb_grants", 64'(n), 64'(4));
        desc_valid_i = 2'b00;
        wait_idle("arb_done");

        // len=6 on requester 0: padding bytes 77/88 must never appear.
        load_words(0, {32'h0, 32'h88776655, 32'h44332211}, 2);
        expect_bytes(0, 6, {32'h0, 32'h88776655, 32'h44332211}, 6);
        @(negedge clk);
        send_desc(0, 6);
        #4;
        check("data_ready_latency", 64'(data_ready_o), 64'(2'b01));
        @(negedge clk);
        #4;
        check("first_byte_latency", 64'({byte_valid_o, byte_o}), 64'({1'b1, 8'h11}));
        @(negedge clk);
        wait_idle("len6_done");
        check("len6_words_used", 64'(wq0.size()), 64'(0));

        // Zero-length descriptor is consumed without any activity.
        send_desc(1, 0);
        seen = 1'b0;
        repeat (6) begin
            #4;
            if (busy_o || byte_valid_o) seen = 1'b1;
            @(negedge clk);
        end
        check("len0_quiet", 64'(seen), 64'(0));

        // Backpressure for 10 cycles after the second byte.
        load_words(0, {32'h0, 32'hE4E3E2E1, 32'hD4D3D2D1}, 2);
        expect_bytes(0, 8, {32'h0, 32'hE4E3E2E1, 32'hD4D3D2D1}, 8);
        @(negedge clk);
        send_desc(0, 8);
        wait_bytes(2, f0, l0);
        byte_ready_i = 1'b0;
        #4;
        held = {byte_valid_o, byte_o, byte_last_o, byte_src_o};
        stable_ok = 1'b1;
        repeat (9) begin
            @(negedge clk);
            #4;
            if ({byte_valid_o, byte_o, byte_last_o, byte_src_o} !== held) stable_ok = 1'b0;
        end
        check("stall_value", 64'(held), 64'({1'b1, 8'hD3, 1'b0, 1'b0}));
        check("stall_stable", 64'(stable_ok), 64'(1));
        @(negedge clk);
        byte_ready_i = 1'b1;
        wait_bytes(6, f1, l1);
        check("stall_span", 64'(l1 - f0), 64'(18));
        wait_idle("stall_done");

        // Abort after two bytes of a three-word transfer.
        load_words(0, {32'hCCCBCAC9, 32'hC8C7C6C5, 32'hC4C3C2C1}, 3);
        expect_bytes(0, 12, {32'hCCCBCAC9, 32'hC8C7C6C5, 32'hC4C3C2C1}, 2);
        @(negedge clk);
        send_desc(0, 12);
        wait_bytes(2, f0, l0);
        abort_i = 1'b1;
        byte_ready_i = 1'b0;
        @(negedge clk);
        abort_i = 1'b0;
        byte_ready_i = 1'b1;
        #4;
        check("abort_next_cycle", 64'({byte_valid_o, busy_o, data_ready_o, byte_o}),
              64'({1'b0, 1'b1, 2'b01, 8'h00}));
        @(negedge clk);
        wait_idle("abort_drain_done");
        check("abort_drained", 64'(wq0.size()), 64'(0));
        load_words(0, {64'h0, 32'hF4F3F2F1}, 1);
        expect_bytes(0, 3, {64'h0, 32'hF4F3F2F1}, 3);
        @(negedge clk);
        send_desc(0, 3);
        wait_idle("fresh_after_abort");

        // Reset while shifting.
        load_words(1, {32'h0, 32'h9B9A9998, 32'h97969594}, 2);
        expect_bytes(1, 8, {32'h0, 32'h9B9A9998, 32'h97969594}, 1);
        @(negedge clk);
        send_desc(1, 8);
        wait_bytes(1, f0, l0);
        rst_i = 1'b1;
        byte_ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        #4;
        check("reset_mid_shift",
              64'({byte_valid_o, busy_o, byte_last_o, byte_src_o, data_ready_o, desc_ready_o, byte_o}),
              64'(0));
        @(negedge clk);
        wq1.delete();
        load_words(1, {64'h0, 32'h0000A5A6}, 1);
        expect_bytes(1, 2, {64'h0, 32'h0000A5A6}, 2);
        byte_ready_i = 1'b1;
        @(negedge clk);
        send_desc(1, 2);
        wait_idle("after_reset_done");

        check("scoreboard_empty", 64'(expq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
